acumulador_sumas: RTL and testbench
===================================

ACUMULADOR_SUMAS -- requirements
Module: acumulador_sumas

Interface
REQ-001 The block SHALL have parameter N_MUESTRAS, default 4, giving samples summed per block; legal range 1..32.
REQ-002 The block SHALL have parameter PROF_FIFO, default 4, giving result FIFO depth; legal values 2, 4, 8.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 in_valid  input  1  upstream sum sample present on in_data.
REQ-006 in_data  input  4  unsigned 4-bit sum sample from the upstream adder stage.
REQ-007 in_ready  output  1  block accepts a sample this cycle.
REQ-008 out_valid  output  1  FIFO head entry present on out_data/out_ovf.
REQ-009 out_data  output  8  accumulated block sum, FIFO head.
REQ-010 out_ovf  output  1  overflow flag of FIFO head entry.
REQ-011 out_ready  input  1  downstream consumes head entry this cycle.
REQ-012 ocupacion  output  4  number of FIFO entries, 0..PROF_FIFO.

Function
REQ-013 A sample SHALL be accepted on a rising edge where in_valid and in_ready are both 1; no other cycle alters accumulation state.
REQ-014 The FSM SHALL have exactly two states: ACUM and PUSH.
REQ-015 In ACUM, in_ready SHALL be 1; each accepted sample adds in_data, zero-extended, to the 8-bit accumulator and increments the sample counter.
REQ-016 On acceptance of sample number N_MUESTRAS, the FSM SHALL move to PUSH holding the final sum; the sample counter and accumulator clear on leaving PUSH.
REQ-017 In PUSH, in_ready SHALL be 0; the held sum and flag are written to the FIFO on the first edge where the FIFO is not full, or is full with a pop in the same cycle; the FSM then returns to ACUM.
REQ-018 With an empty FIFO and out_ready=1, the sum whose last sample is accepted at edge t SHALL be written at edge t+1 and present with out_valid=1 during cycle t+2.
REQ-019 out_valid SHALL equal (ocupacion != 0); out_data/out_ovf SHALL be the oldest entry; a pop occurs when out_valid and out_ready are both 1.
REQ-020 Simultaneous push and pop SHALL leave ocupacion unchanged and preserve FIFO order.
REQ-021 A pop while empty or a push while full without a simultaneous pop SHALL never occur; FIFO pointers wrap modulo PROF_FIFO.
REQ-022 out_data and out_ovf SHALL remain stable while out_valid=1 and out_ready=0.
REQ-023 A carry out of bit 7 during any addition in a block SHALL set that block's overflow indication.

Reset
REQ-024 While rst=1 at a rising edge: FSM to ACUM, accumulator 0, sample counter 0, FIFO pointers 0, ocupacion 0, out_valid 0, out_data 0, out_ovf 0.
REQ-025 in_ready SHALL be 0 during any cycle in which rst=1, and 1 in the first cycle after rst deasserts.
REQ-026 Reset mid-block or in PUSH SHALL discard the partial sum and all FIFO contents; no partial result is emitted.

Configuration
REQ-027 Macro ACUMULADOR_SATURA_EN SHALL select overflow handling.
REQ-028 With ACUMULADOR_SATURA_EN defined: on carry the accumulator clamps at 255 for the rest of the block, and the entry's out_ovf is 1.
REQ-029 Without ACUMULADOR_SATURA_EN: the accumulator wraps modulo 256, and out_ovf is constant 0.

Verification
REQ-030 N=4, out_ready=1, samples 1,2,3,4 on consecutive cycles -> out_data=10, out_ovf=0, out_valid asserted exactly 2 cycles after last acceptance, for one cycle.
REQ-031 N=4, out_ready=0, 5 blocks of samples 15,15,15,15 back-to-back -> 4 entries of 60 with ocupacion=4; 5th block holds in PUSH with in_ready=0; raising out_ready drains 60 x5 in order.
REQ-032 N=20, twenty samples of 15 -> with macro: out_data=255, out_ovf=1; without macro: out_data=44, out_ovf=0.
REQ-033 FIFO full, FSM in PUSH, out_ready=1 for one cycle -> push and pop on the same edge, ocupacion stays 4, order preserved.
REQ-034 N=4, rst pulsed after 2 samples (7,8), then samples 1,1,1,1 -> single output 4, no output containing 15.
REQ-035 in_valid toggled randomly with samples of 3, N=4 -> every output equals 12; no sample lost or duplicated.

Source files
------------

// File: rtl/acumulador_sumas.sv
// acumulador_sumas: sums blocks of N_MUESTRAS unsigned 4-bit samples into an
// 8-bit result and queues each block result in a PROF_FIFO-deep output FIFO.
// Optional feature macro: ACUMULADOR_SATURA_EN (saturate at 255 and flag
// overflow); without it the sum wraps modulo 256 and out_ovf is held at 0.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   in_valid/in_data       upstream sample handshake (4-bit sample)
//   in_ready               sample accepted this cycle (low in PUSH or reset)
//   out_valid/out_data     FIFO head entry (8-bit block sum)
//   out_ovf                overflow flag of the head entry
//   out_ready              downstream pops the head entry
//   ocupacion              FIFO entry count, 0..PROF_FIFO
module acumulador_sumas #(
   parameter int unsigned N_MUESTRAS = 4,
   parameter int unsigned PROF_FIFO  = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   input  logic [3:0] in_data,
   output logic       in_ready,
   output logic       out_valid,
   output logic [7:0] out_data,
   output logic       out_ovf,
   input  logic       out_ready,
   output logic [3:0] ocupacion
);

   localparam int unsigned CNT_W = 6;
   localparam int unsigned PTR_W = $clog2(PROF_FIFO);
   localparam int unsigned OCU_W = 4;

   typedef enum logic {ACUM, PUSH} estado_t;

   estado_t           estado, estado_sig;
   logic [7:0]        acc;
   logic [CNT_W-1:0]  cnt;
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [OCU_W-1:0]  ocu;
   logic [7:0]        mem_dat [PROF_FIFO];

   logic acepta_c, lleno_c, pop_c, push_c;

   assign acepta_c = in_valid && (estado == ACUM);
   assign lleno_c  = (ocu == OCU_W'(PROF_FIFO));
   assign pop_c    = out_valid && out_ready;
   // Push also allowed into a full FIFO when the head leaves on the same edge.
   assign push_c   = (estado == PUSH) && (!lleno_c || pop_c);

   // in_ready is gated by rst directly so it drops in the reset cycle itself.
   assign in_ready  = (estado == ACUM) && !rst;
   assign out_valid = (ocu != '0);
   assign out_data  = out_valid ? mem_dat[rd_ptr] : 8'h00;
   assign ocupacion = ocu;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) estado <= ACUM;
      else     estado <= estado_sig;
   end

   // Next-state logic.
   always_comb begin
      estado_sig = estado;
      case (estado)
         ACUM: if (in_valid && (cnt == CNT_W'(N_MUESTRAS - 1))) estado_sig = PUSH;
         PUSH: if (push_c) estado_sig = ACUM;
         default: estado_sig = ACUM;
      endcase
   end

`ifdef ACUMULADOR_SATURA_EN
   logic       ovf;
   logic [8:0] suma_c;
   logic       mem_ovf [PROF_FIFO];

   assign suma_c  = {1'b0, acc} + 9'(in_data);
   assign out_ovf = out_valid ? mem_ovf[rd_ptr] : 1'b0;

   // Accumulator with clamp at 255; ovf is sticky for the rest of the block.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc <= 8'h00;
         cnt <= '0;
         ovf <= 1'b0;
      end else if (acepta_c) begin
         cnt <= cnt + CNT_W'(1);
         if (suma_c[8]) begin
            acc <= 8'hFF;
            ovf <= 1'b1;
         end else begin
            acc <= suma_c[7:0];
         end
      end else if (push_c) begin
         acc <= 8'h00;
         cnt <= '0;
         ovf <= 1'b0;
      end
   end

   // Overflow flag storage alongside the data.
   always_ff @(posedge clk) begin
      if (push_c) mem_ovf[wr_ptr] <= ovf;
   end
`else
   assign out_ovf = 1'b0;

   // Accumulator wrapping modulo 256.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc <= 8'h00;
         cnt <= '0;
      end else if (acepta_c) begin
         acc <= acc + 8'(in_data);
         cnt <= cnt + CNT_W'(1);
      end else if (push_c) begin
         acc <= 8'h00;
         cnt <= '0;
      end
   end
`endif

   // FIFO data storage.
   always_ff @(posedge clk) begin
      if (push_c) mem_dat[wr_ptr] <= acc;
   end

   // FIFO pointers and occupancy; power-of-two depth makes pointers wrap.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         ocu    <= '0;
      end else begin
         if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
         if (push_c && !pop_c)      ocu <= ocu + OCU_W'(1);
         else if (pop_c && !push_c) ocu <= ocu - OCU_W'(1);
      end
   end

endmodule

// File: tb/tb_acumulador_sumas.sv
// Testbench for acumulador_sumas: scoreboard of expected block sums computed
// from plain arithmetic on the accepted samples, monitor popping on handshakes.
module tb_acumulador_sumas;

   localparam int unsigned N = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic [3:0] in_data;
   logic       in_ready;
   logic       out_valid;
   logic [7:0] out_data;
   logic       out_ovf;
   logic       out_ready;
   logic [3:0] ocupacion;

   logic       in_valid20;
   logic [3:0] in_data20;
   logic       in_ready20;
   logic       out_valid20;
   logic [7:0] out_data20;
   logic       out_ovf20;
   logic       out_ready20;
   logic [3:0] ocupacion20;

   int vectors = 0;
   int errs    = 0;

   int exp_d[$];
   int exp_o[$];
   int blk_total = 0;
   int blk_n     = 0;

   logic hold;
   int   hold_d, hold_o;
   logic fin_rand;

   always #5 clk = ~clk;

   acumulador_sumas #(.N_MUESTRAS(N), .PROF_FIFO(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
      .out_ovf(out_ovf), .out_ready(out_ready), .ocupacion(ocupacion)
   );

   acumulador_sumas #(.N_MUESTRAS(20), .PROF_FIFO(2)) dut20 (
      .clk(clk), .rst(rst), .in_valid(in_valid20), .in_data(in_data20),
      .in_ready(in_ready20), .out_valid(out_valid20), .out_data(out_data20),
      .out_ovf(out_ovf20), .out_ready(out_ready20), .ocupacion(ocupacion20)
   );

   task automatic chk(input string nombre, input int act, input int req);
      vectors++;
      if (act != req) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d at %0t", nombre, act, req, $time);
      end
   endtask

   // Expected block result from the total of its samples.
   function automatic void modelo(input int total, output int d, output int o);
`ifdef ACUMULADOR_SATURA_EN
      if (total > 255) begin d = 255; o = 1; end
      else begin d = total; o = 0; end
`else
      d = total % 256;
      o = 0;
`endif
   endfunction

   // Offer one sample and wait until it is accepted.
   task automatic send(input int d);
      int ed, eo;
      logic ok;
      ok = 1'b0;
      in_valid = 1'b1;
      in_data  = 4'(d);
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1'b1;
            blk_total += d;
            blk_n++;
            if (blk_n == int'(N)) begin
               modelo(blk_total, ed, eo);
               exp_d.push_back(ed);
               exp_o.push_back(eo);
               blk_total = 0;
               blk_n = 0;
            end
            @(posedge clk);
            #1;
            break;
         end
      end
      if (!ok) begin
         chk("send_timeout", 0, 1);
         in_valid = 1'b0;
      end
   endtask

   task automatic idle(input int k);
      in_valid = 1'b0;
      repeat (k) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drain();
      out_ready = 1'b1;
      for (int i = 0; i < 400; i++) begin
         @(posedge clk);
         #2;
         if (exp_d.size() == 0 && ocupacion == 4'd0) break;
      end
      chk("drain_pending", exp_d.size(), 0);
      chk("drain_ocupacion", int'(ocupacion), 0);
   endtask

   // Monitor: pops expectations on each handshake, checks head stability.
   always @(negedge clk) begin
      if (rst) begin
         hold = 1'b0;
      end else begin
         chk("valid_vs_ocupacion", int'(out_valid), int'(ocupacion != 4'd0));
         if (out_valid) begin
            if (hold) begin
               chk("stable_data", int'(out_data), hold_d);
               chk("stable_ovf", int'(out_ovf), hold_o);
            end
            if (out_ready) begin
               hold = 1'b0;
               if (exp_d.size() == 0) begin
                  chk("unexpected_output", int'(out_data), -1);
               end else begin
                  int ed, eo;
                  ed = exp_d.pop_front();
                  eo = exp_o.pop_front();
                  chk("out_data", int'(out_data), ed);
                  chk("out_ovf", int'(out_ovf), eo);
               end
            end else begin
               hold   = 1'b1;
               hold_d = int'(out_data);
               hold_o = int'(out_ovf);
            end
         end else begin
            hold = 1'b0;
         end
      end
   end

   initial begin
      int ed, eo;
      logic visto;
      rst = 1'b1;
      in_valid = 1'b0;
      in_data = 4'd0;
      out_ready = 1'b0;
      in_valid20 = 1'b0;
      in_data20 = 4'd0;
      out_ready20 = 1'b1;
      fin_rand = 1'b0;
      hold = 1'b0;

      // Reset state.
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", int'(in_ready), 0);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_ocupacion", int'(ocupacion), 0);
      chk("rst_out_data", int'(out_data), 0);
      chk("rst_out_ovf", int'(out_ovf), 0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("in_ready_after_rst", int'(in_ready), 1);
      @(posedge clk);
      #1;

      // 1,2,3,4 back to back: result 10, visible two cycles after last accept.
      out_ready = 1'b1;
      send(1); send(2); send(3); send(4);
      in_valid = 1'b0;
      @(negedge clk);
      chk("lat_cycle1_valid", int'(out_valid), 0);
      @(negedge clk);
      chk("lat_cycle2_valid", int'(out_valid), 1);
      chk("lat_cycle2_data", int'(out_data), 10);
      @(negedge clk);
      chk("lat_cycle3_valid", int'(out_valid), 0);
      @(posedge clk);
      #1;

      // Five blocks of 15s with out_ready low: FIFO fills, fifth block holds.
      out_ready = 1'b0;
      for (int i = 0; i < 5 * int'(N); i++) send(15);
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("full_ocupacion", int'(ocupacion), 4);
      chk("full_in_ready", int'(in_ready), 0);
      chk("full_out_valid", int'(out_valid), 1);
      // One-cycle pop while held in PUSH: simultaneous push and pop.
      @(posedge clk);
      #1 out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      @(negedge clk);
      chk("pushpop_ocupacion", int'(ocupacion), 4);
      chk("pushpop_in_ready", int'(in_ready), 1);
      drain();

      // Reset mid-block discards the partial 7+8.
      out_ready = 1'b1;
      send(7); send(8);
      in_valid = 1'b0;
      rst = 1'b1;
      blk_total = 0;
      blk_n = 0;
      exp_d.delete();
      exp_o.delete();
      @(negedge clk);
      chk("midrst_in_ready", int'(in_ready), 0);
      @(posedge clk);
      #1 rst = 1'b0;
      send(1); send(1); send(1); send(1);
      in_valid = 1'b0;
      drain();

      // Twenty samples of 15 into the N=20 instance.
      in_valid20 = 1'b1;
      in_data20  = 4'd15;
      repeat (20) @(posedge clk);
      #1 in_valid20 = 1'b0;
      visto = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (out_valid20) begin
            visto = 1'b1;
            break;
         end
      end
      modelo(20 * 15, ed, eo);
      chk("n20_valid", int'(visto), 1);
      chk("n20_data", int'(out_data20), ed);
      chk("n20_ovf", int'(out_ovf20), eo);
      @(posedge clk);
      #1;

      // Random gaps with samples of 3, then fully random samples, random out_ready.
      fork
         begin
            for (int i = 0; i < 10 * int'(N); i++) begin
               idle($urandom_range(0, 2));
               send(3);
            end
            for (int i = 0; i < 40 * int'(N); i++) begin
               idle($urandom_range(0, 3));
               send(int'($urandom_range(0, 15)));
            end
            in_valid = 1'b0;
            fin_rand = 1'b1;
         end
         begin
            while (!fin_rand) begin
               @(posedge clk);
               #1 out_ready = 1'($urandom_range(0, 1));
            end
         end
      join
      drain();

      chk("leftover_partial_block", blk_n, 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got 1 expected 0");
      $fatal(1, "timeout");
   end

endmodule
